// File: rtl/mult_share_arb.sv
// Round-robin arbiter that lets NREQ requesters share one pipelined 32x16 signed
// multiplier. Results are returned in issue order through a credit-limited result FIFO.
module mult_share_arb #(
  parameter int NREQ  = 4,
  parameter int LAT   = 2,
  parameter int DEPTH = 4,
  localparam int ID_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*32-1:0]   req_a,
  input  logic [NREQ*16-1:0]   req_b,
  output logic [31:0]          mul_a,
  output logic [15:0]          mul_b,
  output logic                 mul_ce,
  output logic                 mul_reset,
  input  logic [47:0]          mul_dout,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [47:0]          rsp_data,
  output logic [ID_W-1:0]      rsp_id,
  output logic                 busy
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [ID_W-1:0]  ptr;
  logic [ID_W-1:0]  gnt_idx;
  logic             gnt_found;
  logic             issue;
  logic             pop;
  logic             push;
  logic             full;
  logic [CNT_W-1:0] outstanding;
  logic [CNT_W-1:0] count;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [LAT-1:0]   tag_v;
  logic [ID_W-1:0]  tag_id [LAT];
  logic [47:0]      mem_data [DEPTH];
  logic [ID_W-1:0]  mem_id   [DEPTH];

  // NOTE: every variable gets a default at the top of the block so no path leaves it
  // unassigned; otherwise synthesis infers a latch.
  always_comb begin : arb
    int j;
    gnt_found = 1'b0;
    gnt_idx   = '0;
    j         = 0;
    for (int k = 0; k < NREQ; k++) begin
      j = (int'(ptr) + k) % NREQ;
      if (!gnt_found && req_valid[j]) begin
        gnt_found = 1'b1;
        gnt_idx   = ID_W'(j);
      end
    end
  end

  // A pop this cycle frees its credit for an issue in the same cycle.
  assign pop   = rsp_valid & rsp_ready;
  assign issue = reset_n & gnt_found & ((outstanding < CNT_W'(DEPTH)) | pop);

  assign req_ready = issue ? (NREQ'(1) << gnt_idx) : '0;
  assign mul_a     = issue ? req_a[int'(gnt_idx)*32 +: 32] : '0;
  assign mul_b     = issue ? req_b[int'(gnt_idx)*16 +: 16] : '0;
  assign mul_ce    = 1'b1;
  assign mul_reset = ~reset_n;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of the order the always blocks are evaluated.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr <= '0;
    end else if (issue) begin
      ptr <= (gnt_idx == ID_W'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      outstanding <= '0;
    end else begin
      case ({issue, pop})
        2'b10:   outstanding <= outstanding + 1'b1;
        2'b01:   outstanding <= outstanding - 1'b1;
        default: outstanding <= outstanding;
      endcase
    end
  end

  // Tag pipeline mirrors the multiplier latency so the last stage lines up with mul_dout.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tag_v <= '0;
      for (int k = 0; k < LAT; k++) tag_id[k] <= '0;
    end else begin
      tag_v[0]  <= issue;
      tag_id[0] <= gnt_idx;
      for (int k = 1; k < LAT; k++) begin
        tag_v[k]  <= tag_v[k-1];
        tag_id[k] <= tag_id[k-1];
      end
    end
  end

  assign push = tag_v[LAT-1];
  assign full = (count == CNT_W'(DEPTH));

  // NOTE: the storage array has no reset; only the pointers and count need one,
  // and leaving the array reset-free lets it map onto plain RAM/register cells.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_data[wr_ptr] <= mul_dout;
      mem_id[wr_ptr]   <= tag_id[LAT-1];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      if (pop)  rd_ptr <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign rsp_valid = (count != '0);
  assign rsp_data  = mem_data[rd_ptr];
  assign rsp_id    = mem_id[rd_ptr];
  assign busy      = (outstanding != '0);

  // The credit counter bounds pipeline plus FIFO occupancy, so a full FIFO never sees a push.
  a_no_overflow: assert property (@(posedge clk) disable iff (!reset_n) !(push && full));

endmodule

// File: tb/tb_mult_share_arb.sv
// Directed bench for mult_share_arb: issue-time expectations go into a scoreboard queue,
// a separate monitor pops and compares whenever a response is accepted.
module tb_mult_share_arb;

  localparam int NREQ  = 4;
  localparam int LAT   = 2;
  localparam int DEPTH = 4;

  logic              clk = 1'b0;
  logic              reset_n;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*32-1:0] req_a;
  logic [NREQ*16-1:0] req_b;
  logic [31:0]       mul_a;
  logic [15:0]       mul_b;
  logic              mul_ce;
  logic              mul_reset;
  logic [47:0]       mul_dout;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [47:0]       rsp_data;
  logic [1:0]        rsp_id;
  logic              busy;

  typedef struct packed {
    logic [1:0]  id;
    logic [47:0] data;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] exp_a    [NREQ];
  logic [15:0] exp_b    [NREQ];
  logic [47:0] exp_prod [NREQ];
  int          n_vec = 0;
  int          n_err = 0;

  mult_share_arb #(.NREQ(NREQ), .LAT(LAT), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .mul_a     (mul_a),
    .mul_b     (mul_b),
    .mul_ce    (mul_ce),
    .mul_reset (mul_reset),
    .mul_dout  (mul_dout),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_id    (rsp_id),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Two-stage signed multiplier: input register then product register.
  logic [31:0] m_a_r;
  logic [15:0] m_b_r;
  logic [47:0] m_p_r;
  always_ff @(posedge clk) begin
    if (mul_reset) begin
      m_a_r <= '0;
      m_b_r <= '0;
      m_p_r <= '0;
    end else if (mul_ce) begin
      m_a_r <= mul_a;
      m_b_r <= mul_b;
      m_p_r <= {{16{m_a_r[31]}}, m_a_r} * {{32{m_b_r[15]}}, m_b_r};
    end
  end
  assign mul_dout = m_p_r;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_ops(input int i, input logic [31:0] a, input logic [15:0] b,
                         input logic [47:0] p);
    req_a[i*32 +: 32] = a;
    req_b[i*16 +: 16] = b;
    exp_a[i]          = a;
    exp_b[i]          = b;
    exp_prod[i]       = p;
  endtask

  // One clock cycle of stimulus with the hand-derived one-hot grant for that cycle.
  task automatic cycle(input logic [3:0] v, input logic rr, input logic [3:0] exp_rdy);
    logic [31:0] ea;
    logic [15:0] eb;
    @(negedge clk);
    req_valid = v;
    rsp_ready = rr;
    #1;
    ea = '0;
    eb = '0;
    check("req_ready", 64'(req_ready), 64'(exp_rdy));
    for (int i = 0; i < NREQ; i++) begin
      if (exp_rdy[i]) begin
        exp_q.push_back('{id: 2'(i), data: exp_prod[i]});
        ea = exp_a[i];
        eb = exp_b[i];
      end
    end
    check("mul_a", 64'(mul_a), 64'(ea));
    check("mul_b", 64'(mul_b), 64'(eb));
    @(posedge clk);
    #1;
  endtask

  task automatic wait_drain();
    int cyc;
    cyc       = 0;
    req_valid = '0;
    rsp_ready = 1'b1;
    while ((exp_q.size() != 0 || busy) && cyc < 100) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    check("drain_queue_empty", 64'(exp_q.size()), 64'd0);
    check("busy_after_drain", 64'(busy), 64'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n   = 1'b0;
    req_valid = '0;
    exp_q.delete();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Monitor: pops the scoreboard on every accepted response.
  always begin : monitor
    exp_t e;
    @(negedge clk);
    #2;
    if (reset_n && rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_rsp: got id %0d data %h, expected no response", rsp_id, rsp_data);
      end else begin
        e = exp_q.pop_front();
        check("rsp_data", 64'(rsp_data), 64'(e.data));
        check("rsp_id", 64'(rsp_id), 64'(e.id));
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    reset_n   = 1'b0;
    req_valid = '1;
    rsp_ready = 1'b0;
    req_a     = '0;
    req_b     = '0;
    set_ops(0, 32'h0000_0003, 16'h0005, 48'h0000_0000_000F);
    set_ops(1, 32'h7FFF_FFFF, 16'h7FFF, 48'h3FFF_7FFF_8001);
    set_ops(2, 32'h0000_0010, 16'hFFFE, 48'hFFFF_FFFF_FFE0);
    set_ops(3, 32'hFFFF_FFF6, 16'h0007, 48'hFFFF_FFFF_FFBA);

    // Reset values with all requesters asking.
    repeat (2) @(negedge clk);
    #1;
    check("rst_req_ready", 64'(req_ready), 64'd0);
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_mul_a", 64'(mul_a), 64'd0);
    check("rst_mul_b", 64'(mul_b), 64'd0);
    check("rst_mul_reset", 64'(mul_reset), 64'd1);
    check("mul_ce", 64'(mul_ce), 64'd1);
    req_valid = '0;
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    check("mul_reset_released", 64'(mul_reset), 64'd0);

    // Single small product, first cycle after reset.
    cycle(4'b0001, 1'b1, 4'b0001);
    wait_drain();

    // Signed corner products on requester 0.
    set_ops(0, 32'hFFFF_FFFF, 16'h8000, 48'h0000_0000_8000);
    cycle(4'b0001, 1'b1, 4'b0001);
    set_ops(0, 32'h8000_0000, 16'h8000, 48'h4000_0000_0000);
    cycle(4'b0001, 1'b1, 4'b0001);
    wait_drain();
    set_ops(0, 32'h0000_0003, 16'h0005, 48'h0000_0000_000F);

    // All requesters held: strict rotation 0,1,2,3,0,1,2,3 with no stalls.
    do_reset();
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < NREQ; i++) cycle(4'b1111, 1'b1, 4'(1 << i));
    end
    wait_drain();

    // Credit limit: four accepts, stall, then one pop frees one issue.
    for (int i = 0; i < DEPTH; i++) cycle(4'b0001, 1'b0, 4'b0001);
    for (int i = 0; i < 3; i++) cycle(4'b0001, 1'b0, 4'b0000);
    check("busy_at_limit", 64'(busy), 64'd1);
    check("rsp_valid_at_limit", 64'(rsp_valid), 64'd1);
    cycle(4'b0001, 1'b1, 4'b0001);
    cycle(4'b0001, 1'b0, 4'b0000);
    wait_drain();

    // Pointer skip and wrap.
    do_reset();
    cycle(4'b0101, 1'b1, 4'b0001);
    cycle(4'b0100, 1'b1, 4'b0100);
    cycle(4'b1001, 1'b1, 4'b1000);
    cycle(4'b1001, 1'b1, 4'b0001);
    cycle(4'b1010, 1'b1, 4'b0010);
    wait_drain();

    // Reset with two in flight and one queued: everything is discarded.
    for (int i = 0; i < 3; i++) cycle(4'b0001, 1'b0, 4'b0001);
    check("rsp_valid_queued", 64'(rsp_valid), 64'd1);
    check("busy_inflight", 64'(busy), 64'd1);
    @(negedge clk);
    reset_n   = 1'b0;
    req_valid = '0;
    exp_q.delete();
    #1;
    check("rsp_valid_on_reset", 64'(rsp_valid), 64'd0);
    check("busy_on_reset", 64'(busy), 64'd0);
    repeat (2) @(negedge clk);
    reset_n   = 1'b1;
    rsp_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk);
      #1;
      check("no_rsp_after_reset", 64'(rsp_valid), 64'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
